// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data memory and dmem_arbiter.
// Handshake: a requester raises x_req with x_wnr/x_address/x_in stable and holds it until
// the one-cycle x_ack pulse; x_out is valid with the ack on reads and holds afterwards.
interface dmem_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
);
  logic              a_req;
  logic              a_wnr;
  logic [ADDR_W-1:0] a_address;
  logic [WIDTH-1:0]  a_in;
  logic              a_ack;
  logic [WIDTH-1:0]  a_out;

  logic              b_req;
  logic              b_wnr;
  logic [ADDR_W-1:0] b_address;
  logic [WIDTH-1:0]  b_in;
  logic              b_ack;
  logic [WIDTH-1:0]  b_out;

  logic              mem_wnr;
  logic [ADDR_W-1:0] mem_address;
  logic [WIDTH-1:0]  mem_in;
  logic [WIDTH-1:0]  mem_out;

  logic              busy;
  logic              owner;

  modport master (
    output a_req, a_wnr, a_address, a_in,
    output b_req, b_wnr, b_address, b_in,
    output mem_out,
    input  a_ack, a_out, b_ack, b_out,
    input  mem_wnr, mem_address, mem_in, busy, owner
  );

  modport slave (
    input  a_req, a_wnr, a_address, a_in,
    input  b_req, b_wnr, b_address, b_in,
    input  mem_out,
    output a_ack, a_out, b_ack, b_out,
    output mem_wnr, mem_address, mem_in, busy, owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the combinationally-written data memory (setup/strobe/resp).
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port A has fixed priority.
module dmem_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     bus,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_q;
  logic              wnr_q;
  logic              mem_wnr_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [WIDTH-1:0]  mem_in_q;
  logic              a_ack_q;
  logic              b_ack_q;
  logic [WIDTH-1:0]  a_out_q;
  logic [WIDTH-1:0]  b_out_q;
  logic              busy_q;
  logic              owner_q;
  logic              grant_b;

`ifdef DMEM_ARB_RR_EN
  // last_grant_q: 1 = port B won most recently, so A takes the next tie.
  logic last_grant_q;
  always_comb grant_b = bus.b_req && (!bus.a_req || !last_grant_q);
`else
  always_comb grant_b = bus.b_req && !bus.a_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wnr_q         <= 1'b0;
      mem_wnr_q     <= 1'b0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_out_q       <= '0;
      b_out_q       <= '0;
      busy_q        <= 1'b0;
      owner_q       <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_grant_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.a_req || bus.b_req) begin
            owner_q       <= grant_b;
            wnr_q         <= grant_b ? bus.b_wnr     : bus.a_wnr;
            mem_address_q <= grant_b ? bus.b_address : bus.a_address;
            mem_in_q      <= grant_b ? bus.b_in      : bus.a_in;
            busy_q        <= 1'b1;
            state_q       <= SETUP;
`ifdef DMEM_ARB_RR_EN
            last_grant_q  <= grant_b;
`endif
          end
        end
        SETUP: begin
          // Address/data have been on the memory pins for a full cycle before WNR rises.
          mem_wnr_q <= wnr_q;
          state_q   <= STROBE;
        end
        STROBE: begin
          mem_wnr_q <= 1'b0;
          if (!wnr_q) begin
            if (owner_q) b_out_q <= bus.mem_out;
            else         a_out_q <= bus.mem_out;
          end
          if (owner_q) b_ack_q <= 1'b1;
          else         a_ack_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_wnr     = mem_wnr_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_in      = mem_in_q;
  assign bus.a_ack       = a_ack_q;
  assign bus.b_ack       = b_ack_q;
  assign bus.a_out       = a_out_q;
  assign bus.b_out       = b_out_q;
  assign bus.busy        = busy_q;
  assign bus.owner       = owner_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural memory and arbitration model.
module tb_dmem_arbiter;

  localparam int W  = 32;
  localparam int AW = 8;
  localparam int EW = 2 + AW + W;   // {port, wnr, addr, data}
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] state;
  int         cyc;

  dmem_arbiter_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  dmem_arbiter #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, write committed at the clock edge while WNR is high.
  logic [W-1:0] mem [2**AW];
  always @(posedge clk) if (bus.mem_wnr) mem[bus.mem_address] <= bus.mem_in;
  assign bus.mem_out = mem[bus.mem_address];

  // Reference model and scoreboard
  logic [W-1:0]    ref_mem [2**AW];
  logic [EW-1:0]   exp_q[$];
  logic [AW+W-1:0] wr_q[$];
  bit              last_m;
  logic [W-1:0]    exp_a_out, exp_b_out;
  int              n_cmp, n_fail;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void push_txn(input bit port, input bit wnr, input logic [AW-1:0] addr,
                                   input logic [W-1:0] data);
    if (wnr) begin
      ref_mem[addr] = data;
      exp_q.push_back({port, 1'b1, addr, data});
      wr_q.push_back({addr, data});
    end else begin
      exp_q.push_back({port, 1'b0, addr, ref_mem[addr]});
    end
    last_m = port;
  endfunction

  // Ack monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      exp_a_out = '0;
      exp_b_out = '0;
    end else if (bus.a_ack || bus.b_ack) begin
      check("single_ack", {63'd0, bus.a_ack & bus.b_ack}, 64'd0);
      check("busy_in_resp", {63'd0, bus.busy}, 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", {63'd0, bus.b_ack}, {63'd0, e[EW-1]});
        check("owner", {63'd0, bus.owner}, {63'd0, e[EW-1]});
        if (!e[EW-2]) begin
          if (e[EW-1]) exp_b_out = e[W-1:0];
          else         exp_a_out = e[W-1:0];
        end
        check("a_out", {32'd0, bus.a_out}, {32'd0, exp_a_out});
        check("b_out", {32'd0, bus.b_out}, {32'd0, exp_b_out});
      end
    end
  end

  // Write-strobe monitor
  bit            prev_wnr;
  logic [AW-1:0] prev_addr;
  logic [W-1:0]  prev_in;
  always @(negedge clk) begin
    logic [AW+W-1:0] w;
    if (rst) begin
      prev_wnr  = 1'b0;
      prev_addr = '0;
      prev_in   = '0;
    end else begin
      if (prev_wnr) check("wnr_one_cycle", {63'd0, bus.mem_wnr}, 64'd0);
      if (bus.mem_wnr && !prev_wnr) begin
        check("addr_stable_at_rise", {56'd0, bus.mem_address}, {56'd0, prev_addr});
        check("data_stable_at_rise", {32'd0, bus.mem_in}, {32'd0, prev_in});
        if (wr_q.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", {56'd0, bus.mem_address}, {56'd0, w[AW+W-1:W]});
          check("wr_data", {32'd0, bus.mem_in}, {32'd0, w[W-1:0]});
        end
      end
      prev_wnr  = bus.mem_wnr;
      prev_addr = bus.mem_address;
      prev_in   = bus.mem_in;
    end
  end

  // Driver tasks
  task automatic drive_port(input bit port, input bit wnr, input logic [AW-1:0] addr,
                            input logic [W-1:0] data);
    if (port) begin
      bus.b_wnr = wnr; bus.b_address = addr; bus.b_in = data; bus.b_req = 1'b1;
    end else begin
      bus.a_wnr = wnr; bus.a_address = addr; bus.a_in = data; bus.a_req = 1'b1;
    end
  endtask

  task automatic do_single(input bit port, input bit wnr, input logic [AW-1:0] addr,
                           input logic [W-1:0] data);
    int start;
    bit got;
    @(posedge clk); #1;
    drive_port(port, wnr, addr, data);
    push_txn(port, wnr, addr, data);
    start = cyc;
    got   = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (port ? bus.b_ack : bus.a_ack) begin
        got = 1'b1;
        check("latency", 64'(cyc - start), 64'd3);
      end
    end
    if (!got) check("single_ack_timeout", 64'd0, 64'd1);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
  endtask

  task automatic do_pair(input bit wa, input logic [AW-1:0] aa, input logic [W-1:0] da,
                         input bit wb, input logic [AW-1:0] ab, input logic [W-1:0] db);
    bit a_done, b_done;
    a_done = 1'b0;
    b_done = 1'b0;
    @(posedge clk); #1;
    drive_port(1'b0, wa, aa, da);
    drive_port(1'b1, wb, ab, db);
    // Tie: round-robin favours the port that did not win last; fixed favours A.
    if (RR && last_m == 1'b0) begin
      push_txn(1'b1, wb, ab, db);
      push_txn(1'b0, wa, aa, da);
    end else begin
      push_txn(1'b0, wa, aa, da);
      push_txn(1'b1, wb, ab, db);
    end
    for (int i = 0; i < 40 && !(a_done && b_done); i++) begin
      @(negedge clk);
      if (bus.a_ack) begin a_done = 1'b1; bus.a_req = 1'b0; end
      if (bus.b_ack) begin b_done = 1'b1; bus.b_req = 1'b0; end
    end
    if (!(a_done && b_done)) check("pair_ack_timeout", 64'd0, 64'd1);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
  endtask

  task automatic do_held4(input logic [AW-1:0] aa, input logic [AW-1:0] ab);
    int  n;
    bit  win;
    n = 0;
    @(posedge clk); #1;
    drive_port(1'b0, 1'b0, aa, '0);
    drive_port(1'b1, 1'b0, ab, '0);
    for (int k = 0; k < 4; k++) begin
      win = RR && (last_m == 1'b0);
      push_txn(win, 1'b0, win ? ab : aa, '0);
    end
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (bus.a_ack || bus.b_ack) n++;
      if (n == 4) begin bus.a_req = 1'b0; bus.b_req = 1'b0; end
    end
    if (n < 4) check("held_ack_timeout", 64'd0, 64'd1);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, output bit found);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (state == s) found = 1'b1;
    end
    if (!found) check("state_timeout", 64'd0, 64'd1);
  endtask

  // Main sequence
  initial begin
    bit           found;
    int           acks;
    int           sel;
    logic [W-1:0] d0, d1;

    for (int i = 0; i < 2**AW; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    cyc = 0; n_cmp = 0; n_fail = 0; last_m = 1'b1;
    exp_a_out = '0; exp_b_out = '0;
    bus.a_req = 0; bus.a_wnr = 0; bus.a_address = '0; bus.a_in = '0;
    bus.b_req = 0; bus.b_wnr = 0; bus.b_address = '0; bus.b_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_mem_wnr", {63'd0, bus.mem_wnr}, 64'd0);
    check("rst_mem_address", {56'd0, bus.mem_address}, 64'd0);
    check("rst_mem_in", {32'd0, bus.mem_in}, 64'd0);
    check("rst_acks", {62'd0, bus.a_ack, bus.b_ack}, 64'd0);
    check("rst_outs", {bus.a_out, bus.b_out}, 64'd0);
    check("rst_busy_owner", {62'd0, bus.busy, bus.owner}, 64'd0);
    check("rst_state", {62'd0, state}, 64'd0);
    rst = 1'b0;

    // Directed write then cross-port read of the same word
    do_single(1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    do_single(1'b1, 1'b0, 8'h10, '0);

    // Both ports holding read requests for four grants
    do_held4(8'h10, 8'h05);

    // Random mix of lone and simultaneous requests
    for (int r = 0; r < 30; r++) begin
      sel = $urandom_range(0, 2);
      d0  = $urandom;
      d1  = $urandom;
      if (sel == 2)
        do_pair(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), d0,
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), d1);
      else
        do_single(1'(sel), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), d0);
    end

    // Request dropped and fields changed during SETUP
    @(posedge clk); #1;
    drive_port(1'b0, 1'b1, 8'h30, 32'h1234_5678);
    push_txn(1'b0, 1'b1, 8'h30, 32'h1234_5678);
    wait_state(2'd1, found);
    bus.a_address = 8'h31;
    bus.a_in      = 32'hFFFF_0000;
    bus.a_req     = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.a_ack) acks++;
    end
    check("ack_once_after_drop", 64'(acks), 64'd1);
    do_single(1'b1, 1'b0, 8'h30, '0);
    do_single(1'b1, 1'b0, 8'h31, '0);

    // Reset in the strobe cycle aborts the write
    @(posedge clk); #1;
    drive_port(1'b0, 1'b1, 8'h20, 32'hCAFE_F00D);
    wr_q.push_back({8'h20, 32'hCAFE_F00D});
    wait_state(2'd2, found);
    #1 rst = 1'b1;
    #1;
    check("abort_mem_wnr", {63'd0, bus.mem_wnr}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_a_ack", {63'd0, bus.a_ack}, 64'd0);
    bus.a_req = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    wr_q.delete();
    last_m = 1'b1;
    rst = 1'b0;
    do_single(1'b0, 1'b0, 8'h20, '0);

    repeat (4) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
